// File: rtl/vga_layer_mixer_pkg.sv
// Shared constants and types for the VGA layer mixer: colour defaults,
// screen geometry and the alert FSM state encoding.
package vga_layer_mixer_pkg;

  localparam int          VGA_RGB_W  = 12;
  localparam logic [11:0] VGA_BLACK  = 12'h000;
  localparam logic [11:0] VGA_BG     = 12'h000;
  localparam int          VGA_H_RES  = 640;
  localparam int          VGA_V_RES  = 480;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RING = 1'b1
  } alert_state_e;

endpackage

// File: rtl/vga_layer_mixer_blink_divider.sv
// Blink phase generator: free-running divider that flips the blink phase every
// BLINK_DIV clocks. A synchronous restart forces the counter to zero and the
// phase to 1 so a fresh alert always starts visible. o_toggle strobes in the
// cycle whose clock edge will flip the phase.
module vga_layer_mixer_blink_divider #(
  parameter int BLINK_DIV   = 16666666,
  parameter int BLINK_CNT_W = 24
) (
  input  logic clock,
  input  logic reset,
  input  logic i_restart,
  output logic o_blink,
  output logic o_toggle
);

  localparam logic [BLINK_CNT_W-1:0] CNT_MAX = BLINK_CNT_W'(BLINK_DIV - 1);

  logic [BLINK_CNT_W-1:0] r_cnt;
  logic                   r_blink;
  logic                   w_wrap;

  assign w_wrap   = (r_cnt == CNT_MAX);
  assign o_toggle = w_wrap & ~i_restart;
  assign o_blink  = r_blink;

  // Half-period counter and blink phase, with restart taking priority over wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt   <= {BLINK_CNT_W{1'b0}};
      r_blink <= 1'b0;
    end else if (i_restart) begin
      r_cnt   <= {BLINK_CNT_W{1'b0}};
      r_blink <= 1'b1;
    end else if (w_wrap) begin
      r_cnt   <= {BLINK_CNT_W{1'b0}};
      r_blink <= ~r_blink;
    end else begin
      r_cnt   <= r_cnt + {{(BLINK_CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/vga_layer_mixer.sv
// VGA layer mixer: priority-merges NUM_LAYERS {on, RGB} sources (index 0 wins),
// gates alert layers with a blinking, acknowledgeable alert FSM and registers
// the final colour once per pixel_tick.
// Optional feature macro: VGA_MIXER_CURSOR_EN adds a cursor_on input that
// inverts the selected colour while the blink phase is high.
module vga_layer_mixer
  import vga_layer_mixer_pkg::*;
#(
  parameter int               NUM_LAYERS    = 4,
  parameter int               RGB_W         = VGA_RGB_W,
  parameter int               BLINK_DIV     = 16666666,
  parameter int               BLINK_CNT_W   = 24,
  parameter int               ALERT_TOGGLES = 32,
  parameter logic [RGB_W-1:0] BG_COLOR      = RGB_W'(VGA_BG)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        pixel_tick,
  input  logic                        video_on,
  input  logic [NUM_LAYERS-1:0]       layer_on,
  input  logic [NUM_LAYERS*RGB_W-1:0] layer_rgb,
  input  logic [NUM_LAYERS-1:0]       layer_gate,
  input  logic [NUM_LAYERS-1:0]       layer_alert,
  input  logic                        alert_req,
  input  logic                        alert_ack,
`ifdef VGA_MIXER_CURSOR_EN
  input  logic                        cursor_on,
`endif
  output logic                        alert_active,
  output logic                        alert_timeout,
  output logic                        blink,
  output logic [RGB_W-1:0]            RGB
);

  localparam int             TOG_W    = (ALERT_TOGGLES > 1) ? $clog2(ALERT_TOGGLES) : 1;
  localparam logic [TOG_W-1:0] TOG_LAST = TOG_W'(ALERT_TOGGLES - 1);

  alert_state_e          r_state;
  logic [TOG_W-1:0]      r_tog_cnt;
  logic                  r_alert_timeout;
  logic [RGB_W-1:0]      r_rgb;

  logic                  w_restart;
  logic                  w_toggle;
  logic                  w_blink;
  logic [NUM_LAYERS-1:0] w_visible;
  logic [RGB_W-1:0]      w_sel_rgb;
  logic [RGB_W-1:0]      w_mix_rgb;
  logic [RGB_W-1:0]      w_next_rgb;

  // Acknowledge always beats a request arriving in the same cycle.
  assign w_restart = alert_req & ~alert_ack;

  vga_layer_mixer_blink_divider #(
    .BLINK_DIV   (BLINK_DIV),
    .BLINK_CNT_W (BLINK_CNT_W)
  ) u_blink_divider (
    .clock     (clock),
    .reset     (reset),
    .i_restart (w_restart),
    .o_blink   (w_blink),
    .o_toggle  (w_toggle)
  );

  // Alert FSM: enter/restart on request, leave on ack or after the toggle budget.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_tog_cnt       <= {TOG_W{1'b0}};
      r_alert_timeout <= 1'b0;
    end else begin
      r_alert_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_restart) begin
            r_state   <= ST_RING;
            r_tog_cnt <= {TOG_W{1'b0}};
          end else begin
            r_state   <= ST_IDLE;
          end
        end
        ST_RING: begin
          if (alert_ack) begin
            r_state <= ST_IDLE;
          end else if (alert_req) begin
            r_tog_cnt <= {TOG_W{1'b0}};
          end else if (w_toggle) begin
            if (r_tog_cnt == TOG_LAST) begin
              r_state         <= ST_IDLE;
              r_alert_timeout <= 1'b1;
            end else begin
              r_tog_cnt <= r_tog_cnt + {{(TOG_W-1){1'b0}}, 1'b1};
            end
          end else begin
            r_state <= ST_RING;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign alert_active  = (r_state == ST_RING);
  assign alert_timeout = r_alert_timeout;
  assign blink         = w_blink;

  // Alert layers only show while an alert rings and the blink phase is high.
  assign w_visible = layer_on & layer_gate &
                     (~layer_alert | {NUM_LAYERS{alert_active & w_blink}});

  // Priority mux: scan from lowest priority up so the lowest visible index wins.
  always_comb begin
    w_sel_rgb = BG_COLOR;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (w_visible[i]) begin
        w_sel_rgb = layer_rgb[i*RGB_W +: RGB_W];
      end else begin
        w_sel_rgb = w_sel_rgb;
      end
    end
  end

  // Cursor inversion (optional) and blanking outside the visible region.
  always_comb begin
`ifdef VGA_MIXER_CURSOR_EN
    if (cursor_on & w_blink) begin
      w_mix_rgb = ~w_sel_rgb;
    end else begin
      w_mix_rgb = w_sel_rgb;
    end
`else
    w_mix_rgb = w_sel_rgb;
`endif
    if (video_on) begin
      w_next_rgb = w_mix_rgb;
    end else begin
      w_next_rgb = {RGB_W{1'b0}};
    end
  end

  // Output pixel register, advanced only on pixel_tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rgb <= {RGB_W{1'b0}};
    end else if (pixel_tick) begin
      r_rgb <= w_next_rgb;
    end else begin
      r_rgb <= r_rgb;
    end
  end

  assign RGB = r_rgb;

endmodule

// File: tb/tb_vga_layer_mixer.sv
// Directed self-checking bench for vga_layer_mixer (BLINK_DIV=4,
// ALERT_TOGGLES=3, pixel_tick every 4th cycle). Define VGA_MIXER_CURSOR_EN
// to include the cursor scenario.
module tb_vga_layer_mixer;

  logic        clock;
  logic        reset;
  logic        pixel_tick;
  logic        video_on;
  logic [3:0]  layer_on;
  logic [47:0] layer_rgb;
  logic [3:0]  layer_gate;
  logic [3:0]  layer_alert;
  logic        alert_req;
  logic        alert_ack;
`ifdef VGA_MIXER_CURSOR_EN
  logic        cursor_on;
`endif
  logic        alert_active;
  logic        alert_timeout;
  logic        blink;
  logic [11:0] RGB;

  int checks;
  int failures;
  int cyc;

  vga_layer_mixer #(
    .NUM_LAYERS    (4),
    .RGB_W         (12),
    .BLINK_DIV     (4),
    .BLINK_CNT_W   (24),
    .ALERT_TOGGLES (3),
    .BG_COLOR      (12'h00F)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .pixel_tick    (pixel_tick),
    .video_on      (video_on),
    .layer_on      (layer_on),
    .layer_rgb     (layer_rgb),
    .layer_gate    (layer_gate),
    .layer_alert   (layer_alert),
    .alert_req     (alert_req),
    .alert_ack     (alert_ack),
`ifdef VGA_MIXER_CURSOR_EN
    .cursor_on     (cursor_on),
`endif
    .alert_active  (alert_active),
    .alert_timeout (alert_timeout),
    .blink         (blink),
    .RGB           (RGB)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One clock; inputs change 1 time unit after the edge, pixel_tick every 4th cycle.
  task automatic step();
    @(posedge clock);
    #1;
    cyc = cyc + 1;
    pixel_tick = ((cyc % 4) == 3);
  endtask

  // Advance until an edge with pixel_tick=1 has been taken.
  task automatic run_to_tick(input string name);
    logic t;
    bit   seen;
    seen = 1'b0;
    for (int n = 0; n < 8 && !seen; n++) begin
      t = pixel_tick;
      step();
      if (t) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s: no pixel_tick within 8 cycles", name);
    end
  endtask

  task automatic set_rgb(input logic [11:0] c0, input logic [11:0] c1,
                         input logic [11:0] c2, input logic [11:0] c3);
    layer_rgb = {c3, c2, c1, c0};
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (RGB !== 12'h000 || blink !== 1'b0 || alert_active !== 1'b0 || alert_timeout !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: RGB=%h blink=%b active=%b timeout=%b, required 000 0 0 0",
               RGB, blink, alert_active, alert_timeout);
    end
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_priority();
    video_on = 1'b1; layer_gate = 4'b1111; layer_alert = 4'b0000;
    layer_on = 4'b0110;
    set_rgb(12'h123, 12'hF00, 12'h0F0, 12'h456);
    run_to_tick("prio_a");
    checks++;
    if (RGB !== 12'hF00) begin
      failures++; $display("FAIL prio_layer1: RGB=%h required F00", RGB);
    end
    // Change inputs with no tick at the next edge: RGB must hold.
    layer_gate = 4'b1101;
    step();
    checks++;
    if (RGB !== 12'hF00) begin
      failures++; $display("FAIL prio_hold: RGB=%h required F00", RGB);
    end
    run_to_tick("prio_b");
    checks++;
    if (RGB !== 12'h0F0) begin
      failures++; $display("FAIL prio_gate_off: RGB=%h required 0F0", RGB);
    end
    layer_gate = 4'b1111; layer_on = 4'b1000;
    run_to_tick("prio_c");
    checks++;
    if (RGB !== 12'h456) begin
      failures++; $display("FAIL prio_layer3: RGB=%h required 456", RGB);
    end
    layer_on = 4'b1111;
    run_to_tick("prio_d");
    checks++;
    if (RGB !== 12'h123) begin
      failures++; $display("FAIL prio_layer0: RGB=%h required 123", RGB);
    end
  endtask

  task automatic test_video_bg();
    layer_on = 4'b1111; video_on = 1'b0;
    run_to_tick("video_a");
    checks++;
    if (RGB !== 12'h000) begin
      failures++; $display("FAIL video_off: RGB=%h required 000", RGB);
    end
    layer_on = 4'b0000; video_on = 1'b1;
    run_to_tick("video_b");
    checks++;
    if (RGB !== 12'h00F) begin
      failures++; $display("FAIL background: RGB=%h required 00F", RGB);
    end
    // Alert-only layer with no active alert stays hidden.
    layer_on = 4'b0001; layer_alert = 4'b0001;
    run_to_tick("video_c");
    checks++;
    if (RGB !== 12'h00F) begin
      failures++; $display("FAIL alert_hidden: RGB=%h required 00F", RGB);
    end
  endtask

  task automatic test_alert_timeout();
    logic        t;
    logic        eb, ea, eto;
    logic        pb, pa;
    logic [11:0] exp_rgb;
    int          to_count;
    layer_on = 4'b0011; layer_alert = 4'b0001; layer_gate = 4'b1111;
    set_rgb(12'hFFF, 12'h0F0, 12'h000, 12'h000);
    run_to_tick("alert_pre");
    checks++;
    if (RGB !== 12'h0F0) begin
      failures++; $display("FAIL alert_pre_rgb: RGB=%h required 0F0", RGB);
    end
    alert_req = 1'b1;
    step();
    alert_req = 1'b0;
    checks++;
    if (alert_active !== 1'b1 || blink !== 1'b1) begin
      failures++; $display("FAIL alert_entry: active=%b blink=%b required 1 1", alert_active, blink);
    end
    exp_rgb = 12'h0F0; pb = 1'b1; pa = 1'b1; to_count = 0;
    for (int k = 1; k <= 13; k++) begin
      t = pixel_tick;
      step();
      eb  = (((k / 4) % 2) == 0);
      ea  = (k < 12);
      eto = (k == 12);
      if (t) exp_rgb = (pa && pb) ? 12'hFFF : 12'h0F0;
      if (alert_timeout === 1'b1) to_count++;
      checks++;
      if (blink !== eb || alert_active !== ea || alert_timeout !== eto || RGB !== exp_rgb) begin
        failures++;
        $display("FAIL alert_seq k=%0d: blink=%b active=%b timeout=%b RGB=%h required %b %b %b %h",
                 k, blink, alert_active, alert_timeout, RGB, eb, ea, eto, exp_rgb);
      end
      pb = eb; pa = ea;
    end
    checks++;
    if (to_count != 1) begin
      failures++; $display("FAIL alert_timeout_count: got %0d required 1", to_count);
    end
  endtask

  task automatic test_ack();
    int to_seen;
    alert_req = 1'b1;
    step();
    alert_req = 1'b0;
    repeat (5) step();
    checks++;
    if (alert_active !== 1'b1) begin
      failures++; $display("FAIL ack_ringing: active=%b required 1", alert_active);
    end
    alert_ack = 1'b1;
    step();
    alert_ack = 1'b0;
    checks++;
    if (alert_active !== 1'b0 || alert_timeout !== 1'b0) begin
      failures++; $display("FAIL ack_exit: active=%b timeout=%b required 0 0", alert_active, alert_timeout);
    end
    to_seen = 0;
    for (int k = 0; k < 14; k++) begin
      step();
      if (alert_timeout !== 1'b0 || alert_active !== 1'b0) to_seen++;
    end
    checks++;
    if (to_seen != 0) begin
      failures++; $display("FAIL ack_quiet: %0d cycles with activity, required 0", to_seen);
    end
    alert_req = 1'b1; alert_ack = 1'b1;
    step();
    alert_req = 1'b0; alert_ack = 1'b0;
    checks++;
    if (alert_active !== 1'b0) begin
      failures++; $display("FAIL req_ack_same: active=%b required 0", alert_active);
    end
  endtask

  task automatic test_restart();
    alert_req = 1'b1;
    step();
    alert_req = 1'b0;
    repeat (8) step();
    alert_req = 1'b1;
    step();
    alert_req = 1'b0;
    checks++;
    if (alert_active !== 1'b1 || blink !== 1'b1) begin
      failures++; $display("FAIL restart_entry: active=%b blink=%b required 1 1", alert_active, blink);
    end
    repeat (11) step();
    checks++;
    if (alert_active !== 1'b1 || alert_timeout !== 1'b0) begin
      failures++; $display("FAIL restart_extended: active=%b timeout=%b required 1 0", alert_active, alert_timeout);
    end
    step();
    checks++;
    if (alert_active !== 1'b0 || alert_timeout !== 1'b1) begin
      failures++; $display("FAIL restart_timeout: active=%b timeout=%b required 0 1", alert_active, alert_timeout);
    end
    step();
  endtask

  task automatic test_reset_mid_ring();
    logic eb;
    layer_on = 4'b0010; layer_alert = 4'b0000;
    run_to_tick("rst_pre");
    alert_req = 1'b1;
    step();
    alert_req = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
    checks++;
    if (RGB !== 12'h000 || blink !== 1'b0 || alert_active !== 1'b0 || alert_timeout !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: RGB=%h blink=%b active=%b timeout=%b, required 000 0 0 0",
               RGB, blink, alert_active, alert_timeout);
    end
    step();
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      eb = (k == 4);
      checks++;
      if (blink !== eb || alert_active !== 1'b0 || alert_timeout !== 1'b0) begin
        failures++;
        $display("FAIL reset_release k=%0d: blink=%b active=%b timeout=%b required %b 0 0",
                 k, blink, alert_active, alert_timeout, eb);
      end
    end
  endtask

`ifdef VGA_MIXER_CURSOR_EN
  task automatic test_cursor();
    logic        t;
    logic        pb;
    logic [11:0] exp_rgb;
    layer_on = 4'b0010; layer_alert = 4'b0000; video_on = 1'b1;
    set_rgb(12'h000, 12'h0F0, 12'h000, 12'h000);
    cursor_on = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_rgb = 12'h000; pb = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      t = pixel_tick;
      step();
      if (t) exp_rgb = pb ? 12'hF0F : 12'h0F0;
      pb = (((k / 4) % 2) == 1);
      checks++;
      if (RGB !== exp_rgb || blink !== pb) begin
        failures++;
        $display("FAIL cursor k=%0d: RGB=%h blink=%b required %h %b", k, RGB, blink, exp_rgb, pb);
      end
    end
    cursor_on = 1'b0;
  endtask
`endif

  initial begin
    checks = 0; failures = 0; cyc = 0;
    reset = 1'b1; pixel_tick = 1'b0; video_on = 1'b0;
    layer_on = 4'b0000; layer_rgb = 48'h0; layer_gate = 4'b0000; layer_alert = 4'b0000;
    alert_req = 1'b0; alert_ack = 1'b0;
`ifdef VGA_MIXER_CURSOR_EN
    cursor_on = 1'b0;
`endif
    test_reset();
    test_priority();
    test_video_bg();
    test_alert_timeout();
    test_ack();
    test_restart();
    test_reset_mid_ring();
`ifdef VGA_MIXER_CURSOR_EN
    test_cursor();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
